led_stretch: RTL

LED_STRETCH -- requirements
Module: led_stretch

---
 rtl/led_pkg.sv | 19 +
 rtl/led_stretch_chan.sv | 45 ++++
 rtl/led_stretch.sv | 59 +++++
 3 files changed

// File: rtl/led_pkg.sv
// Shared constants and helpers for the LED pulse stretcher.
package led_pkg;

  localparam int HOLD_W         = 8;
  localparam int N_LED_DEF      = 8;
  localparam int CLK_HZ_DEF     = 160000000;
  localparam int STRETCH_MS_DEF = 20;
  localparam int PWM_BITS_DEF   = 8;

  // Clocks per millisecond tick
  function automatic int ms_div(input int clk_hz);
    return clk_hz / 1000;
  endfunction

  function automatic int cnt_w(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/led_stretch_chan.sv
// One LED channel: input synchronizer, millisecond hold counter, registered lit output.
module led_stretch_chan
  import led_pkg::*;
#(
  parameter int STRETCH_MS = STRETCH_MS_DEF
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_led,
  input  logic i_ms_tick,
  input  logic i_pwm_on,
  output logic o_led
);

  logic              r_sync1;
  logic              r_sync2;
  logic [HOLD_W-1:0] r_hold;
  logic              r_lit;
  logic              w_hold_nz;
  logic              w_active;

  assign w_hold_nz = (r_hold != '0);
  assign w_active  = r_sync2 | w_hold_nz;

  // A live input reloads the hold, which wins over a coincident tick decrement
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
      r_hold  <= '0;
      r_lit   <= 1'b0;
    end else begin
      r_sync1 <= i_led;
      r_sync2 <= r_sync1;
      if (r_sync2)
        r_hold <= HOLD_W'(STRETCH_MS);
      else if (i_ms_tick && w_hold_nz)
        r_hold <= r_hold - 1'b1;
      r_lit <= w_active & i_pwm_on;
    end
  end

  assign o_led = r_lit;

endmodule

// File: rtl/led_stretch.sv
// LED pulse stretcher with PWM dimming; shares one ms prescaler and one PWM counter
// across all channels.
module led_stretch
  import led_pkg::*;
#(
  parameter int N_LED      = N_LED_DEF,
  parameter int CLK_HZ     = CLK_HZ_DEF,
  parameter int STRETCH_MS = STRETCH_MS_DEF,
  parameter int PWM_BITS   = PWM_BITS_DEF
) (
  input  logic                clock,
  input  logic                async_res,
  input  logic [N_LED-1:0]    led_in,
  input  logic [PWM_BITS-1:0] brightness,
  output logic [N_LED-1:0]    led_out,
  output logic [N_LED-1:0]    led_n
);

  localparam int DIV   = ms_div(CLK_HZ);
  localparam int PRE_W = cnt_w(DIV);

  logic [PRE_W-1:0]    r_presc;
  logic [PWM_BITS-1:0] r_pwm;
  logic                w_ms_tick;
  logic                w_pwm_on;
  logic [N_LED-1:0]    w_led;

  assign w_ms_tick = (r_presc == PRE_W'(DIV - 1));

  always_ff @(posedge clock or posedge async_res) begin
    if (async_res) begin
      r_presc <= '0;
      r_pwm   <= '0;
    end else begin
      r_presc <= w_ms_tick ? '0 : r_presc + 1'b1;
      r_pwm   <= r_pwm + 1'b1;
    end
  end

  // Full scale bypasses the compare so the LED never blinks off at the wrap
  assign w_pwm_on = (brightness == '1) || (r_pwm < brightness);

  for (genvar g = 0; g < N_LED; g++) begin : g_chan
    led_stretch_chan #(
      .STRETCH_MS (STRETCH_MS)
    ) u_chan (
      .i_clk     (clock),
      .i_rst     (async_res),
      .i_led     (led_in[g]),
      .i_ms_tick (w_ms_tick),
      .i_pwm_on  (w_pwm_on),
      .o_led     (w_led[g])
    );
  end

  assign led_out = w_led;
  assign led_n   = ~w_led;

endmodule
